cpu_clock_enable_ctrl: RTL
==========================

Name: cpu_clock_enable_ctrl

Overview:
Run/step/halt scheduler for the MIPS core's clock. It does not divide or gate the clock. It generates a single-cycle clock-enable pulse at a programmable rate (period DIV+1 cycles), in continuous RUN or for a counted number of STEP cycles. Commands arrive from the debug unit over a valid/ready handshake. The pipeline advances only on cycles where o_cpu_enable is high.

Parameters:
NB_DIV, 4, width of the rate divider register; pulse period = div_reg+1 cycles (1..2^NB_DIV)
NB_ARG, 16, width of the command argument (step count / divider value)
NB_CYCLES, 32, width of the issued-pulse counter

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&&ready at rising edge
i_cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 SET_DIV
i_cmd_arg  in  NB_ARG  STEP: cycle count; SET_DIV: low NB_DIV bits = div value
i_program_end  in  1  core reports end of program; ends RUN/STEP
o_cpu_enable  out  1  one-cycle advance pulse to the core
o_busy  out  1  high in RUN or STEP
o_done  out  1  one-cycle pulse when RUN/STEP terminates
o_cmd_error  out  1  one-cycle pulse: command accepted but ignored
o_state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 DONE
o_cycle_count  out  NB_CYCLES  total enable pulses since reset, wraps

Behaviour:
- One clock: i_clock. Reset is synchronous and active-high on i_reset.
- Reset values: state IDLE, div_reg 0, prescaler 0, remaining 0, cycle_count 0. All outputs 0 except o_cmd_ready=1.
- o_cmd_ready = (state != DONE).
- o_cpu_enable = (state==RUN || state==STEP) && prescaler==div_reg. It is decoded from registers only, with no combinational path from inputs.
- o_busy = (state==RUN || state==STEP).
- Prescaler behaviour:
  - Cleared to 0 on every entry to RUN/STEP.
  - While active it counts 0..div_reg, then wraps to 0.
  - Held at 0 in IDLE/DONE.
- IDLE transitions on an accepted command:
  - RUN -> RUN.
  - STEP with arg>0 -> STEP, remaining<=arg.
  - STEP with arg==0 -> DONE, no pulse.
  - SET_DIV -> div_reg<=arg[NB_DIV-1:0], stay IDLE.
  - HALT -> stay IDLE, o_cmd_error pulse.
- Latency: with the command accepted at edge T, the first o_cpu_enable occurs in cycle T+1+div_reg. After that, pulses occur every div_reg+1 cycles.
- RUN:
  - Continues until an accepted HALT or i_program_end sampled high; either takes it to DONE at the next edge.
  - An enable pulse in the same cycle is still issued (not suppressed).
  - Accepted RUN/STEP/SET_DIV are ignored and pulse o_cmd_error.
- STEP:
  - Each enable pulse decrements remaining.
  - A pulse issued while remaining==1 -> DONE at the next edge.
  - HALT or i_program_end -> DONE at the next edge; the remaining count is discarded.
  - Other commands are ignored with o_cmd_error.
- DONE: lasts exactly one cycle with o_done=1, o_cmd_ready=0, then IDLE.
- Simultaneous events:
  - HALT accepted and i_program_end in the same cycle give a single DONE.
  - A final STEP pulse coinciding with HALT gives a single DONE.
- div_reg changes only via SET_DIV in IDLE, so the rate is stable within a run.
- o_cycle_count increments by 1 on every cycle o_cpu_enable=1 and wraps modulo 2^NB_CYCLES.
- i_program_end is ignored in IDLE/DONE.
- Reset mid-RUN/STEP: at the next edge every register takes its reset value (div_reg back to 0). No o_done is generated.

Test Plan:
- Reset, then RUN with div_reg=0; HALT accepted 5 cycles later. Required: o_cpu_enable high every cycle from T+1; exactly 5 pulses before DONE; o_done one cycle; o_cycle_count=5.
- SET_DIV arg=3, then STEP arg=4. Required: pulses at T+4, T+8, T+12, T+16; DONE in T+17; o_cycle_count=4; o_busy low after.
- STEP arg=0. Required: DONE the next cycle, no pulse, o_done=1, o_cycle_count unchanged.
- RUN with div 1; i_program_end asserted on a pulse cycle. Required: that pulse counted; DONE next cycle; no further pulses.
- During RUN, issue SET_DIV and STEP. Required: o_cmd_ready=1, o_cmd_error pulses for each; div_reg and state unchanged. In IDLE, HALT gives o_cmd_error.
- i_reset asserted mid-STEP (remaining=7, div=2). Required: next cycle state IDLE, o_cpu_enable 0, o_cycle_count 0, div_reg 0, no o_done.

Source files
------------

// File: rtl/cpu_clock_enable_ctrl.sv
// cpu_clock_enable_ctrl: run/step/halt scheduler emitting rate-divided one-cycle enable pulses to the core
module cpu_clock_enable_ctrl #(
  parameter int NB_DIV    = 4,
  parameter int NB_ARG    = 16,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [NB_ARG-1:0]    i_cmd_arg,
  input  logic                 i_program_end,
  output logic                 o_cpu_enable,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cmd_error,
  output logic [1:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
);
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_DONE = 2'b11;
  localparam logic [1:0] OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_SET_DIV = 2'b11;
  logic [1:0]           state, state_next;
  logic [NB_DIV-1:0]    div_reg, prescaler;
  logic [NB_ARG-1:0]    remaining;
  logic [NB_CYCLES-1:0] cycle_count;
  logic                 cmd_error_q, err_next;
  logic                 active, next_active, enable, accept, halt_acc, idle_cmd;
  assign active      = (state == S_RUN) || (state == S_STEP);
  assign next_active = (state_next == S_RUN) || (state_next == S_STEP);
  assign enable      = active && (prescaler == div_reg);
  assign accept      = i_cmd_valid && (state != S_DONE);
  assign halt_acc    = accept && (i_cmd_op == OP_HALT);
  assign idle_cmd    = (state == S_IDLE) && accept;
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && i_cmd_op == OP_RUN) state_next = S_RUN;
        if (accept && i_cmd_op == OP_STEP) state_next = (i_cmd_arg != '0) ? S_STEP : S_DONE;
        err_next = halt_acc;
      end
      S_RUN: begin
        state_next = (halt_acc || i_program_end) ? S_DONE : S_RUN;
        err_next   = accept && !halt_acc;
      end
      S_STEP: begin
        state_next = (halt_acc || i_program_end || (enable && remaining == NB_ARG'(1))) ? S_DONE : S_STEP;
        err_next   = accept && !halt_acc;
      end
      default: state_next = S_IDLE;
    endcase
  end
  // prescaler restarts at 0 on every entry to an active state, so the first pulse lands div_reg+1 cycles after acceptance
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div_reg     <= '0;
      prescaler   <= '0;
      remaining   <= '0;
      cycle_count <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      div_reg     <= (idle_cmd && i_cmd_op == OP_SET_DIV) ? i_cmd_arg[NB_DIV-1:0] : div_reg;
      prescaler   <= (active && next_active && !enable) ? prescaler + NB_DIV'(1) : '0;
      remaining   <= (idle_cmd && i_cmd_op == OP_STEP) ? i_cmd_arg :
                     (state_next == S_STEP) ? remaining - NB_ARG'(enable) : '0;
      cycle_count <= cycle_count + NB_CYCLES'(enable);
      cmd_error_q <= err_next;
    end
  end
  always_comb begin
    o_cmd_ready   = state != S_DONE;
    o_cpu_enable  = enable;
    o_busy        = active;
    o_done        = state == S_DONE;
    o_cmd_error   = cmd_error_q;
    o_state       = state;
    o_cycle_count = cycle_count;
  end
endmodule
